implication_writer: RTL and testbench

- Write-back end of the BCP datapath. The unit clause evaluators produce implications as (variable, value) pairs; this block buffers them in a FIFO and applies them to the variable assignment table. The partial SAT and unit clause evaluators read that table as their unassign/val inputs.
- Each drained implication does one of three things: it creates a new assignment, or it is dropped as a duplicate, or it raises a conflict when the variable already holds the opposite value.
- New assignments stream out as trail entries for the backtrack controller. Backtracking clears assignments through an unassign port.

---
 rtl/implication_writer.sv | 195 +++++++++++++++++++
 tb/tb_implication_writer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/implication_writer.sv
// Write-back stage of the BCP datapath: buffers implications from the unit
// clause evaluators and applies them to the variable assignment table.
// New assignments stream out as trail entries; a contradicting implication
// raises a conflict and flushes the buffer until the controller acknowledges.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | accepting and draining implications
// ST_CONFLICT | contradiction seen; buffer flushed, waiting for conflict_ack
module implication_writer #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = 7,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    impl_valid,
    input  logic [VAR_W-1:0]        impl_var,
    input  logic                    impl_val,
    output logic                    impl_ready,
    input  logic                    unassign_valid,
    input  logic [VAR_W-1:0]        unassign_var,
    input  logic                    conflict_ack,
    output logic [NUM_VARIABLE-1:0] var_assigned,
    output logic [NUM_VARIABLE-1:0] var_value,
    output logic                    trail_valid,
    output logic [VAR_W-1:0]        trail_var,
    output logic                    trail_val,
    output logic                    conflict,
    output logic [VAR_W-1:0]        conflict_var,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_CONFLICT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [VAR_W-1:0] mem_var [FIFO_DEPTH];
    logic             mem_val [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push;
    logic             pop;
    logic             drain_en;
    logic             drain_new;
    logic             drain_dup;
    logic             drain_conf;
    logic [VAR_W-1:0] head_var;
    logic             head_val;
    logic             head_assigned;
    logic             head_cur_val;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a contradiction enters CONFLICT, only an ack leaves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_conf) begin
                    state_d = ST_CONFLICT;
                end
            end
            ST_CONFLICT: begin
                if (conflict_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output decode from the state and FIFO occupancy
    always_comb begin
        impl_ready = 1'b0;
        conflict   = 1'b0;
        busy       = (fifo_count != '0);
        case (state_q)
            ST_RUN: begin
                impl_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
            end
            ST_CONFLICT: begin
                conflict = 1'b1;
            end
            default: begin
                impl_ready = 1'b0;
                conflict   = 1'b0;
            end
        endcase
    end

    // Head classification against the current table; unassign stalls the
    // drain so the head never sees a table that is being cleared this cycle
    always_comb begin
        head_var      = mem_var[rd_ptr];
        head_val      = mem_val[rd_ptr];
        head_assigned = var_assigned[head_var];
        head_cur_val  = var_value[head_var];
        push          = impl_valid & impl_ready;
        drain_en      = (state_q == ST_RUN) & (fifo_count != '0) & ~unassign_valid;
        drain_new     = drain_en & ~head_assigned;
        drain_dup     = drain_en & head_assigned & (head_cur_val == head_val);
        drain_conf    = drain_en & head_assigned & (head_cur_val != head_val);
        pop           = drain_new | drain_dup;
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem_var[wr_ptr] <= impl_var;
            mem_val[wr_ptr] <= impl_val;
        end
    end

    // FIFO pointers and occupancy; a conflict discards everything, including
    // an implication pushed on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (drain_conf) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Assignment table: backtrack clears, new implications set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            var_assigned <= '0;
            var_value    <= '0;
        end else if (unassign_valid) begin
            var_assigned[unassign_var] <= 1'b0;
            var_value[unassign_var]    <= 1'b0;
        end else if (drain_new) begin
            var_assigned[head_var] <= 1'b1;
            var_value[head_var]    <= head_val;
        end
    end

    // Trail output: one registered pulse per new assignment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trail_valid <= 1'b0;
            trail_var   <= '0;
            trail_val   <= 1'b0;
        end else begin
            trail_valid <= drain_new;
            if (drain_new) begin
                trail_var <= head_var;
                trail_val <= head_val;
            end
        end
    end

    // Conflict variable capture; held across ack for the controller to read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_var <= '0;
        end else if (drain_conf) begin
            conflict_var <= head_var;
        end
    end

endmodule

// File: tb/tb_implication_writer.sv
// Directed bench for implication_writer with a trail scoreboard.
module tb_implication_writer;

    localparam int NV = 128;
    localparam int VW = 7;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          impl_valid;
    logic [VW-1:0] impl_var;
    logic          impl_val;
    logic          impl_ready;
    logic          unassign_valid;
    logic [VW-1:0] unassign_var;
    logic          conflict_ack;
    logic [NV-1:0] var_assigned;
    logic [NV-1:0] var_value;
    logic          trail_valid;
    logic [VW-1:0] trail_var;
    logic          trail_val;
    logic          conflict;
    logic [VW-1:0] conflict_var;
    logic [CW-1:0] fifo_count;
    logic          busy;

    int vectors = 0;
    int errors  = 0;
    logic [VW:0] sb [$];

    implication_writer dut (
        .clock          (clock),
        .reset          (reset),
        .impl_valid     (impl_valid),
        .impl_var       (impl_var),
        .impl_val       (impl_val),
        .impl_ready     (impl_ready),
        .unassign_valid (unassign_valid),
        .unassign_var   (unassign_var),
        .conflict_ack   (conflict_ack),
        .var_assigned   (var_assigned),
        .var_value      (var_value),
        .trail_valid    (trail_valid),
        .trail_var      (trail_var),
        .trail_val      (trail_val),
        .conflict       (conflict),
        .conflict_var   (conflict_var),
        .fifo_count     (fifo_count),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [NV-1:0] obs, input logic [NV-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, score any trail pulse
    task automatic tick();
        logic [VW:0] e;
        @(posedge clock);
        #1;
        if (trail_valid) begin
            if (sb.size() == 0) begin
                chk("trail_unexpected", trail_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("trail_var", trail_var, e[VW:1]);
                chk("trail_val", trail_val, e[0]);
            end
        end
    endtask

    // Offer one implication for one edge; exp_new marks an expected trail entry
    task automatic offer(input int v, input logic val, input logic acc, input logic exp_new);
        impl_valid = 1'b1;
        impl_var   = VW'(v);
        impl_val   = val;
        chk("impl_ready", impl_ready, acc);
        if (acc && exp_new) sb.push_back({VW'(v), val});
        tick();
        impl_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        impl_valid     = 1'b0;
        impl_var       = '0;
        impl_val       = 1'b0;
        unassign_valid = 1'b0;
        unassign_var   = '0;
        conflict_ack   = 1'b0;
        #12;
        chk("rst_count", fifo_count, 0);
        chk("rst_assigned", var_assigned, 0);
        chk("rst_trail", trail_valid, 0);
        chk("rst_conflict", conflict, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", impl_ready, 1);
        chk("idle_busy", busy, 0);

        // single implication
        offer(5, 1'b1, 1'b1, 1'b1);
        chk("single_count1", fifo_count, 1);
        tick();
        chk("single_assigned", var_assigned[5], 1);
        chk("single_value", var_value[5], 1);
        chk("single_count0", fifo_count, 0);
        tick();
        chk("single_trail_off", trail_valid, 0);
        chk("single_sb", sb.size(), 0);

        // back-pressure with drain stalled by unassign
        unassign_valid = 1'b1;
        unassign_var   = VW'(100);
        for (int i = 0; i < 8; i++) offer(20 + i, 1'(i), 1'b1, 1'b1);
        chk("full_count", fifo_count, 8);
        chk("full_busy", busy, 1);
        offer(30, 1'b1, 1'b0, 1'b0);
        chk("full_hold", fifo_count, 8);
        unassign_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("full_sb", sb.size(), 0);
        chk("full_busy0", busy, 0);
        chk("full_val21", var_value[21], 1);
        tick();

        // duplicate
        offer(3, 1'b0, 1'b1, 1'b1);
        offer(3, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("dup_sb", sb.size(), 0);
        chk("dup_assigned", var_assigned[3], 1);
        chk("dup_value", var_value[3], 0);
        chk("dup_count", fifo_count, 0);

        // conflict
        offer(9, 1'b1, 1'b1, 1'b1);
        offer(2, 1'b1, 1'b1, 1'b1);
        offer(9, 1'b0, 1'b1, 1'b0);
        offer(4, 1'b1, 1'b1, 1'b0);
        chk("conf_flag", conflict, 1);
        chk("conf_var", conflict_var, 9);
        chk("conf_count", fifo_count, 0);
        chk("conf_ready", impl_ready, 0);
        chk("conf_sb", sb.size(), 0);
        tick();
        tick();
        chk("conf_held", conflict, 1);
        chk("conf_v4", var_assigned[4], 0);
        chk("conf_v9", var_value[9], 1);
        conflict_ack = 1'b1;
        tick();
        conflict_ack = 1'b0;
        chk("ack_flag", conflict, 0);
        chk("ack_ready", impl_ready, 1);
        chk("ack_var", conflict_var, 9);
        tick();
        chk("ack_v4", var_assigned[4], 0);

        // backtrack
        offer(7, 1'b1, 1'b1, 1'b1);
        tick();
        chk("bt_set", var_assigned[7], 1);
        unassign_valid = 1'b1;
        unassign_var   = VW'(7);
        tick();
        unassign_valid = 1'b0;
        chk("bt_clear", var_assigned[7], 0);
        chk("bt_value", var_value[7], 0);
        offer(7, 1'b0, 1'b1, 1'b1);
        tick();
        chk("bt_sb", sb.size(), 0);
        chk("bt_reassign", var_assigned[7], 1);
        chk("bt_revalue", var_value[7], 0);

        // async reset mid-operation
        unassign_valid = 1'b1;
        unassign_var   = VW'(101);
        for (int i = 0; i < 5; i++) offer(40 + i, 1'b1, 1'b1, 1'b0);
        chk("ar_count5", fifo_count, 5);
        chk("ar_conf0", conflict, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_count", fifo_count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_assigned", var_assigned, 0);
        chk("ar_value", var_value, 0);
        chk("ar_trail_v", trail_valid, 0);
        chk("ar_trail_var", trail_var, 0);
        chk("ar_trail_val", trail_val, 0);
        chk("ar_conflict", conflict, 0);
        chk("ar_conf_var", conflict_var, 0);
        unassign_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_count", fifo_count, 0);
        chk("post_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
